// File: rtl/seq_detect_pkg.sv
// Shared state encoding and next-state/detect function for the sequence detector.
package seq_detect_pkg;

  typedef enum logic [3:0] {
    ST_A = 4'd0,
    ST_B = 4'd1,
    ST_C = 4'd2,
    ST_D = 4'd3,
    ST_E = 4'd4,
    ST_F = 4'd5,
    ST_G = 4'd6,
    ST_H = 4'd7,
    ST_I = 4'd8
  } state_t;

  typedef struct packed {
    state_t nxt;
    logic   z;
  } det_t;

  // Raw 4-bit input so that the illegal codes 9..15 can be recovered to A.
  function automatic det_t det_next(input logic [3:0] cur, input logic w);
    det_t r;
    r.nxt = ST_A;
    if (cur <= 4'd8) begin
      if (!w) begin
        case (cur)
          4'd1:       r.nxt = ST_C;
          4'd2:       r.nxt = ST_D;
          4'd3, 4'd4: r.nxt = ST_E;
          default:    r.nxt = ST_B;
        endcase
      end else begin
        case (cur)
          4'd5:       r.nxt = ST_G;
          4'd6:       r.nxt = ST_H;
          4'd7, 4'd8: r.nxt = ST_I;
          default:    r.nxt = ST_F;
        endcase
      end
    end
    r.z = (r.nxt == ST_E) || (r.nxt == ST_I);
    return r;
  endfunction

endpackage

// File: rtl/seq_detect_sched_rr_arbiter.sv
// Round-robin arbiter: first eligible channel at or above ptr_i, wrapping mod N_CH.
module rr_arbiter #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CHW  = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] elig_i,
  input  logic [CHW-1:0]  ptr_i,
  output logic [N_CH-1:0] gnt_o,
  output logic [CHW-1:0]  idx_o,
  output logic            vld_o
);

  logic [CHW:0]   sum;
  logic [CHW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      sum = {1'b0, ptr_i} + (CHW+1)'(k);
      if (sum >= (CHW+1)'(N_CH)) sum = sum - (CHW+1)'(N_CH);
      cand = sum[CHW-1:0];
      if (!vld_o && elig_i[cand]) begin
        vld_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/seq_detect_sched.sv
// Time-multiplexed sequence detector over N_CH serial streams with round-robin grant.
// Optional per-channel saturating hit counters under SEQ_DETECT_HIT_COUNT_EN.
module seq_detect_sched
  import seq_detect_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CHW  = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [N_CH-1:0] ch_req,
  input  logic [N_CH-1:0] ch_w,
  input  logic [N_CH-1:0] ch_clr,
  output logic [N_CH-1:0] ch_gnt,
  output logic            z_valid,
  output logic [CHW-1:0]  z_ch,
  output logic            z,
  output logic [3:0]      z_state
`ifdef SEQ_DETECT_HIT_COUNT_EN
  ,
  input  logic [CHW-1:0]  hit_sel,
  output logic [7:0]      hit_cnt
`endif
);

  state_t         st_q [N_CH];
  logic [CHW-1:0] ptr_q, ptr_d;
  logic           z_valid_q, z_q;
  logic [CHW-1:0] z_ch_q;
  state_t         z_state_q;

  logic [N_CH-1:0] elig;
  logic [CHW-1:0]  g_idx;
  logic            xfer;
  det_t            res;

  // Gating with resetn keeps the grant quiet while reset is held.
  assign elig = ch_req & ~ch_clr & {N_CH{resetn}};

  rr_arbiter #(.N_CH(N_CH), .CHW(CHW)) u_arb (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .gnt_o  (ch_gnt),
    .idx_o  (g_idx),
    .vld_o  (xfer)
  );

  assign res = det_next(st_q[g_idx], ch_w[g_idx]);

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = (g_idx == CHW'(N_CH-1)) ? '0 : g_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < N_CH; i++) st_q[i] <= ST_A;
      ptr_q     <= '0;
      z_valid_q <= 1'b0;
      z_ch_q    <= '0;
      z_q       <= 1'b0;
      z_state_q <= ST_A;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (ch_clr[i])                        st_q[i] <= ST_A;
        else if (xfer && g_idx == CHW'(i))    st_q[i] <= res.nxt;
      end
      ptr_q     <= ptr_d;
      z_valid_q <= xfer;
      if (xfer) begin
        z_ch_q    <= g_idx;
        z_q       <= res.z;
        z_state_q <= res.nxt;
      end
    end
  end

  assign z_valid = z_valid_q;
  assign z_ch    = z_ch_q;
  assign z       = z_q;
  assign z_state = z_state_q;

`ifdef SEQ_DETECT_HIT_COUNT_EN
  logic [7:0] cnt_q [N_CH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (ch_clr[i])
          cnt_q[i] <= '0;
        else if (xfer && g_idx == CHW'(i) && res.z && cnt_q[i] != '1)
          cnt_q[i] <= cnt_q[i] + 8'd1;
      end
    end
  end

  assign hit_cnt = (32'(hit_sel) < N_CH) ? cnt_q[hit_sel] : '0;
`endif

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed self-checking bench for seq_detect_sched (N_CH = 4).
module tb_seq_detect_sched;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] ch_req = '0, ch_w = '0, ch_clr = '0;
  logic [3:0] ch_gnt;
  logic       z_valid, z;
  logic [1:0] z_ch;
  logic [3:0] z_state;
`ifdef SEQ_DETECT_HIT_COUNT_EN
  logic [1:0] hit_sel = '0;
  logic [7:0] hit_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_detect_sched #(.N_CH(4)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .ch_req  (ch_req),
    .ch_w    (ch_w),
    .ch_clr  (ch_clr),
    .ch_gnt  (ch_gnt),
    .z_valid (z_valid),
    .z_ch    (z_ch),
    .z       (z),
    .z_state (z_state)
`ifdef SEQ_DETECT_HIT_COUNT_EN
    ,
    .hit_sel (hit_sel),
    .hit_cnt (hit_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [3:0] req, input logic [3:0] w, input logic [3:0] clr);
    ch_req = req;
    ch_w   = w;
    ch_clr = clr;
    #1;
  endtask

  task automatic xfer(input string tag, input logic [3:0] req, input logic [3:0] w,
                      input logic [3:0] clr, input logic [3:0] egnt, input logic [1:0] ech,
                      input logic [3:0] est, input logic ez);
    drv(req, w, clr);
    chk({tag, ".gnt"}, 32'(ch_gnt), 32'(egnt));
    tick();
    chk({tag, ".valid"}, 32'(z_valid), 32'd1);
    chk({tag, ".ch"}, 32'(z_ch), 32'(ech));
    chk({tag, ".state"}, 32'(z_state), 32'(est));
    chk({tag, ".z"}, 32'(z), 32'(ez));
  endtask

  logic [3:0] e1s [5] = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd8};
  logic       e1z [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [3:0] e0s [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
  logic [3:0] gseq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    // Reset held with requests present: no grant, outputs cleared.
    tick();
    drv(4'hF, 4'hF, 4'h0);
    chk("rst.gnt", 32'(ch_gnt), 32'd0);
    chk("rst.valid", 32'(z_valid), 32'd0);
    chk("rst.ch", 32'(z_ch), 32'd0);
    chk("rst.z", 32'(z), 32'd0);
    chk("rst.state", 32'(z_state), 32'd0);
    tick();
    drv(4'h0, 4'h0, 4'h0);
    resetn = 1'b1;
    xfer("t1.first", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 2'd0, 4'd5, 1'b0);

    // Single channel: ones then zeros on ch1.
    for (int i = 0; i < 5; i++)
      xfer("t2.ones", 4'b0010, 4'b0010, 4'b0000, 4'b0010, 2'd1, e1s[i], e1z[i]);
    for (int i = 0; i < 4; i++)
      xfer("t2.zeros", 4'b0010, 4'b0000, 4'b0000, 4'b0010, 2'd1, e0s[i], (i == 3));
    drv(4'h0, 4'h0, 4'h0);
    tick();
    chk("idle.valid", 32'(z_valid), 32'd0);
    chk("idle.ch", 32'(z_ch), 32'd1);
    chk("idle.state", 32'(z_state), 32'd4);
    chk("idle.z", 32'(z), 32'd1);

    // Move ptr to 0 via ch3, then clear every channel.
    xfer("t3.pre", 4'b1000, 4'b0000, 4'b0000, 4'b1000, 2'd3, 4'd1, 1'b0);
    drv(4'hF, 4'h0, 4'hF);
    chk("t3.clrall.gnt", 32'(ch_gnt), 32'd0);
    tick();
    chk("t3.clrall.valid", 32'(z_valid), 32'd0);

    // Fairness: ch0/ch3 stream ones, ch1/ch2 stream zeros.
    for (int k = 0; k < 16; k++)
      xfer("t3.rr", 4'hF, 4'b1001, 4'b0000, gseq[k % 4], 2'(k % 4),
           ((k % 4 == 0) || (k % 4 == 3)) ? e1s[k / 4] : e0s[k / 4], (k / 4 == 3));

    // Clear collision on ch2 (also clears ch0 alongside a ch2 update).
    drv(4'h0, 4'h0, 4'b0100);
    tick();
    xfer("t4.a", 4'b0100, 4'b0100, 4'b0001, 4'b0100, 2'd2, 4'd5, 1'b0);
    xfer("t4.b", 4'b0100, 4'b0100, 4'b0000, 4'b0100, 2'd2, 4'd6, 1'b0);
    xfer("t4.c", 4'b0100, 4'b0100, 4'b0000, 4'b0100, 2'd2, 4'd7, 1'b0);
    drv(4'b0100, 4'b0100, 4'b0100);
    chk("t4.coll.gnt", 32'(ch_gnt), 32'd0);
    tick();
    chk("t4.coll.valid", 32'(z_valid), 32'd0);
    chk("t4.coll.hold", 32'(z_state), 32'd7);
    xfer("t4.after", 4'b0100, 4'b0100, 4'b0000, 4'b0100, 2'd2, 4'd5, 1'b0);

    // Sparse with wrap: ptr=3, only ch1; then ptr=2 picks ch3 over ch1.
    xfer("t5.wrap", 4'b0010, 4'b0010, 4'b0000, 4'b0010, 2'd1, 4'd5, 1'b0);
    xfer("t5.ptr2", 4'b1010, 4'b1010, 4'b0000, 4'b1000, 2'd3, 4'd8, 1'b1);
    xfer("t5.ch0clr", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 2'd0, 4'd5, 1'b0);
    drv(4'h0, 4'h0, 4'h0);
    tick();
    chk("t5.idle.valid", 32'(z_valid), 32'd0);
    chk("t5.idle.ch", 32'(z_ch), 32'd0);

    // Reset asserted mid-stream with a result in flight.
    xfer("t6.pre", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 2'd0, 4'd6, 1'b0);
    drv(4'hF, 4'hF, 4'h0);
    #2 resetn = 1'b0;
    #1;
    chk("t6.rst.gnt", 32'(ch_gnt), 32'd0);
    chk("t6.rst.valid", 32'(z_valid), 32'd0);
    chk("t6.rst.state", 32'(z_state), 32'd0);
    tick();
    drv(4'h0, 4'h0, 4'h0);
    resetn = 1'b1;
    xfer("t6.post", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 2'd0, 4'd5, 1'b0);

`ifdef SEQ_DETECT_HIT_COUNT_EN
    drv(4'h0, 4'h0, 4'b0001);
    tick();
    chk("hit.clr0", 32'(hit_cnt), 32'd0);
    for (int i = 0; i < 260; i++) begin
      drv(4'b0001, 4'b0001, 4'b0000);
      tick();
      if (i == 9) chk("hit.mid", 32'(hit_cnt), 32'd7);
    end
    chk("hit.sat", 32'(hit_cnt), 32'd255);
    drv(4'h0, 4'h0, 4'b0001);
    tick();
    chk("hit.clr", 32'(hit_cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
